frame_swap_ctrl: RTL and testbench

FRAME_SWAP_CTRL -- requirements
Module: frame_swap_ctrl

---
 rtl/fb_pkg.sv | 16 +
 rtl/frame_swap_ctrl.sv | 126 ++++++++++++
 tb/tb_frame_swap_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Framebuffer shared definitions.
// Holds the frame geometry (pixels per 320x240 frame, framebuffer address
// width) and the write-FSM state type. The frame swap controller and the
// address generator both use it.
package fb_pkg;

  localparam int NUM_PIXELS = 76800;
  localparam int ADDR_W     = 17;

  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    WRITE    = 2'd1,
    FULL     = 2'd2
  } wr_state_t;

endpackage

// File: rtl/frame_swap_ctrl.sv
// Double-buffered framebuffer write/swap controller.
// Accepts pixel beats from the effect pipeline, writes each frame
// sequentially into the back bank, and holds the finished frame until the
// scan-out reports end of frame. At that point it swaps the banks, so the
// display only ever changes bank between frames.
//
// Ports:
//   clk_25_vga     - system clock
//   resend         - synchronous active-high reset
//   wr_valid       - pixel beat from the effect pipeline
//   wr_sop         - beat is the first pixel of a frame (qualified by wr_valid)
//   wr_ready       - controller accepts a beat
//   wr_en          - framebuffer write strobe (combinational, zero latency)
//   wr_address     - framebuffer write address
//   wr_bank        - bank being written (always the inverse of rd_bank)
//   vga_start_out  - scan-out start-of-frame pulse (status only, unused here)
//   vga_end_out    - scan-out end-of-frame pulse
//   rd_bank        - bank being scanned out
//   swap_pulse     - one-cycle strobe following a bank swap
//   frames_dropped - saturating count of writer frames aborted by a new sop
module frame_swap_ctrl #(
  parameter int NUM_PIXELS = fb_pkg::NUM_PIXELS,
  parameter int ADDR_W     = fb_pkg::ADDR_W,
  parameter int DROP_W     = 8
) (
  input  logic              clk_25_vga,
  input  logic              resend,
  input  logic              wr_valid,
  input  logic              wr_sop,
  output logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_bank,
  input  logic              vga_start_out,
  input  logic              vga_end_out,
  output logic              rd_bank,
  output logic              swap_pulse,
  output logic [DROP_W-1:0] frames_dropped
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  fb_pkg::wr_state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              accept;
  logic              swap;
  logic              restart;

  // Start-of-frame from scan-out is reserved for status reporting.
  logic unused_start;
  assign unused_start = vga_start_out;

  // A single bank register makes the two banks disjoint by construction.
  assign wr_bank = ~rd_bank;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    wr_ready   = 1'b0;
    accept     = 1'b0;
    wr_en      = 1'b0;
    wr_address = '0;
    swap       = 1'b0;
    restart    = 1'b0;
    if (!resend) begin
      wr_ready = (state != fb_pkg::FULL);
      accept   = wr_valid & wr_ready;
      case (state)
        fb_pkg::WAIT_SOP: begin
          // Beats before the first sop are discarded.
          if (accept && wr_sop) wr_en = 1'b1;
        end
        fb_pkg::WRITE: begin
          if (accept) begin
            wr_en      = 1'b1;
            wr_address = wr_sop ? '0 : cnt;
            restart    = wr_sop;
          end
        end
        fb_pkg::FULL: begin
          if (vga_end_out) begin
            swap      = 1'b1;
            state_nxt = fb_pkg::WAIT_SOP;
          end
        end
        default: state_nxt = fb_pkg::WAIT_SOP;
      endcase
      if (wr_en) begin
        cnt_nxt   = wr_address + ADDR_W'(1);
        state_nxt = fb_pkg::WRITE;
        // Last pixel: park in FULL, or swap straight away if scan-out is
        // finishing its frame on this very edge.
        if (wr_address == LAST_ADDR) begin
          cnt_nxt = '0;
          if (vga_end_out) begin
            swap      = 1'b1;
            state_nxt = fb_pkg::WAIT_SOP;
          end else begin
            state_nxt = fb_pkg::FULL;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_25_vga) begin
    if (resend) begin
      state          <= fb_pkg::WAIT_SOP;
      cnt            <= '0;
      rd_bank        <= 1'b0;
      swap_pulse     <= 1'b0;
      frames_dropped <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rd_bank    <= rd_bank ^ swap;
      swap_pulse <= swap;
      if (restart) frames_dropped <= sat_inc(frames_dropped);
    end
  end

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Bench for frame_swap_ctrl: directed beat sequences with a frame-level
// reference model compared every cycle, plus literal spot values.
module tb_frame_swap_ctrl;

  localparam int NP = 1200;
  localparam int AW = 17;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          resend, wr_valid, wr_sop, vga_start_out, vga_end_out;
  logic          wr_ready, wr_en, wr_bank, rd_bank, swap_pulse;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] frames_dropped;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  frame_swap_ctrl #(.NUM_PIXELS(NP), .ADDR_W(AW), .DROP_W(DW)) dut (
    .clk_25_vga    (clk),
    .resend        (resend),
    .wr_valid      (wr_valid),
    .wr_sop        (wr_sop),
    .wr_ready      (wr_ready),
    .wr_en         (wr_en),
    .wr_address    (wr_address),
    .wr_bank       (wr_bank),
    .vga_start_out (vga_start_out),
    .vga_end_out   (vga_end_out),
    .rd_bank       (rd_bank),
    .swap_pulse    (swap_pulse),
    .frames_dropped(frames_dropped)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: whether a frame is in progress, how many pixels it
  // holds, whether a finished frame is waiting, which bank is on display.
  bit m_in_frame = 1'b0;
  int m_pos      = 0;
  bit m_full     = 1'b0;
  bit m_rd       = 1'b0;
  int m_drop     = 0;
  bit m_swap     = 1'b0;

  always @(negedge clk) begin : cmp
    bit e_ready;
    bit e_wr;
    int e_addr;
    bit done;
    e_ready = !resend && !m_full;
    e_wr    = wr_valid && e_ready && (m_in_frame || wr_sop);
    e_addr  = (e_wr && !wr_sop) ? m_pos : 0;
    if (started) begin
      chk("m_wr_ready", wr_ready, e_ready);
      chk("m_wr_en", wr_en, e_wr);
      chk("m_wr_address", wr_address, e_addr);
      chk("m_rd_bank", rd_bank, m_rd);
      chk("m_wr_bank", wr_bank, !m_rd);
      chk("m_swap_pulse", swap_pulse, m_swap);
      chk("m_frames_dropped", frames_dropped, m_drop);
      chk("m_banks_differ", rd_bank != wr_bank, 1);
      chk("m_addr_range", wr_address <= NP - 1, 1);
    end
    if (resend) begin
      m_in_frame = 1'b0; m_pos = 0; m_full = 1'b0;
      m_rd = 1'b0; m_drop = 0; m_swap = 1'b0;
    end else begin
      done   = e_wr && (e_addr == NP - 1);
      m_swap = (m_full || done) && vga_end_out;
      if (e_wr && wr_sop && m_in_frame && m_drop < (2**DW) - 1) m_drop++;
      if (e_wr) begin
        m_in_frame = 1'b1;
        m_pos      = e_addr + 1;
      end
      if (done) begin
        m_in_frame = 1'b0;
        m_full     = !vga_end_out;
      end else if (m_full && vga_end_out) begin
        m_full = 1'b0;
      end
      if (m_swap) m_rd = !m_rd;
    end
  end

  // Drive inputs just after the rising edge; outputs are then inspected
  // at the following falling edge.
  task automatic step(input bit v, input bit s, input bit e, input bit r);
    @(posedge clk);
    #1;
    wr_valid = v; wr_sop = s; vga_end_out = e; resend = r;
    @(negedge clk);
  endtask

  initial begin
    resend = 1'b1; wr_valid = 1'b0; wr_sop = 1'b0;
    vga_start_out = 1'b0; vga_end_out = 1'b0;

    // Reset, including a sop beat offered during reset.
    step(0, 0, 0, 1);
    started = 1'b1;
    step(0, 0, 0, 1);
    step(1, 1, 0, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_address", wr_address, 0);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_wr_bank", wr_bank, 1);
    chk("rst_frames_dropped", frames_dropped, 0);
    chk("rst_swap_pulse", swap_pulse, 0);

    // Beats without sop are discarded; scan-out start has no effect.
    for (int i = 0; i < 4; i++) begin
      vga_start_out = (i == 1);
      step(1, 0, 0, 0);
      chk("nosop_wr_en", wr_en, 0);
    end
    vga_start_out = 1'b0;

    // First full frame, with an end-of-scan pulse mid-frame (ignored).
    step(1, 1, 0, 0);
    chk("f1_sop_wr_en", wr_en, 1);
    chk("f1_sop_addr", wr_address, 0);
    for (int i = 1; i < NP; i++) begin
      step(1, 0, (i == 10), 0);
      if (i == 11) begin
        chk("f1_midend_rd_bank", rd_bank, 0);
        chk("f1_midend_swap", swap_pulse, 0);
      end
      if (i == 500) chk("f1_addr_500", wr_address, 500);
      if (i == NP - 1) chk("f1_last_addr", wr_address, NP - 1);
    end
    step(1, 0, 0, 0);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_wr_en", wr_en, 0);
    chk("full_wr_bank", wr_bank, 1);
    step(1, 1, 0, 0);
    chk("full_sop_wr_en", wr_en, 0);

    // Swap from FULL.
    step(0, 0, 1, 0);
    chk("swap_not_yet", swap_pulse, 0);
    step(0, 0, 0, 0);
    chk("swap_pulse_hi", swap_pulse, 1);
    chk("swap_rd_bank", rd_bank, 1);
    chk("swap_wr_bank", wr_bank, 0);
    chk("swap_wr_ready", wr_ready, 1);
    step(0, 0, 0, 0);
    chk("swap_pulse_lo", swap_pulse, 0);

    // Restart at beat 500, then a complete frame whose last beat
    // coincides with end of scan.
    step(1, 1, 0, 0);
    for (int i = 1; i < 500; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("restart_addr", wr_address, 0);
    chk("restart_wr_en", wr_en, 1);
    step(1, 0, 0, 0);
    chk("restart_dropped", frames_dropped, 1);
    chk("restart_addr1", wr_address, 1);
    for (int i = 2; i < NP; i++) begin
      step(1, 0, (i == NP - 1), 0);
      if (i == NP - 1) chk("f2_last_addr", wr_address, NP - 1);
    end
    step(1, 0, 0, 0);
    chk("coinc_swap_pulse", swap_pulse, 1);
    chk("coinc_rd_bank", rd_bank, 0);
    chk("coinc_wr_bank", wr_bank, 1);
    chk("coinc_wr_ready", wr_ready, 1);
    chk("coinc_wr_en", wr_en, 0);
    step(0, 0, 0, 0);
    chk("coinc_swap_lo", swap_pulse, 0);

    // Saturation of the drop counter.
    step(1, 1, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 1, 0, 0);
    chk("sat_dropped", frames_dropped, 255);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("sat_dropped_hold", frames_dropped, 255);
    chk("sat_addr1", wr_address, 1);

    // Reset at beat 1000 of a frame.
    for (int i = 2; i < 1000; i++) step(1, 0, 0, 0);
    chk("pre_rst_addr", wr_address, 999);
    step(1, 0, 0, 1);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_addr", wr_address, 0);
    step(0, 0, 0, 0);
    chk("post_rst_dropped", frames_dropped, 0);
    chk("post_rst_rd_bank", rd_bank, 0);
    chk("post_rst_wr_bank", wr_bank, 1);
    chk("post_rst_swap", swap_pulse, 0);
    step(1, 0, 0, 0);
    chk("post_rst_nosop", wr_en, 0);
    step(1, 1, 0, 0);
    chk("post_rst_sop_en", wr_en, 1);
    chk("post_rst_sop_addr", wr_address, 0);
    step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
